// File: rtl/mul_pkg.sv
// mul_pkg: shared mode codes, FSM state encoding and default width for the sequential multiplier.
package mul_pkg;
  localparam int WIDTH_DEF = 32;
  localparam logic [1:0] MODE_MUL    = 2'b00;
  localparam logic [1:0] MODE_MULH   = 2'b01;
  localparam logic [1:0] MODE_MULHSU = 2'b10;
  localparam logic [1:0] MODE_MULHU  = 2'b11;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIX, ST_DONE} state_t;
endpackage

// File: rtl/twos_negate.sv
// twos_negate: passes x through, or its two's-complement negation when neg_i is set.
module twos_negate #(
  parameter int W = 32
) (
  input  logic [W-1:0] x_i,
  input  logic         neg_i,
  output logic [W-1:0] y_o
);
  assign y_o = neg_i ? (~x_i + 1'b1) : x_i;
endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: radix-2 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU, one bit per cycle.
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  state_t             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d, mplier_q, mplier_d, result_q, result_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, prod;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               a_sgn, b_sgn;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     sum;
  assign a_sgn = a[WIDTH-1] & (mode == MODE_MULH || mode == MODE_MULHSU);
  assign b_sgn = b[WIDTH-1] & (mode == MODE_MULH);
  twos_negate #(.W(WIDTH))   u_neg_a (.x_i(a),     .neg_i(a_sgn), .y_o(a_mag));
  twos_negate #(.W(WIDTH))   u_neg_b (.x_i(b),     .neg_i(b_sgn), .y_o(b_mag));
  twos_negate #(.W(2*WIDTH)) u_neg_p (.x_i(acc_q), .neg_i(neg_q), .y_o(prod));
  // carry out of the upper-half add lands in the MSB after the shift
  assign sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mplier_q[0] ? mcand_q : '0};
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    neg_d    = neg_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    result_d = result_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: if (start && !flush) begin
        state_d  = ST_RUN;
        mode_d   = mode;
        mcand_d  = a_mag;
        mplier_d = b_mag;
        neg_d    = a_sgn ^ b_sgn;
        acc_d    = '0;
        cnt_d    = '0;
      end
      ST_RUN: if (flush) state_d = ST_IDLE;
      else begin
        acc_d    = {sum, acc_q[WIDTH-1:1]};
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        state_d  = (cnt_q == CW'(WIDTH - 1)) ? ST_FIX : ST_RUN;
      end
      ST_FIX: if (flush) state_d = ST_IDLE;
      else begin
        result_d = (mode_q == MODE_MUL) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
        state_d  = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mode_q   <= '0;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      result_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      neg_q    <= neg_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      result_q <= result_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end
  assign result = result_q;
  assign done   = (state_q == ST_DONE);
  assign busy   = (state_q == ST_RUN) || (state_q == ST_FIX);
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed and random checks of seq_multiplier against a 64-bit arithmetic model.
module tb_seq_multiplier;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, flush = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [31:0] a = '0, b = '0, result, last = '0;
  logic        done, busy;
  int          n_cmp = 0, n_err = 0;
  seq_multiplier dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b),
    .flush(flush), .result(result), .done(done), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] model(input logic [1:0] m, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] xe, ye, p;
    xe = (m == 2'b01 || m == 2'b10) ? {{32{x[31]}}, x} : {32'b0, x};
    ye = (m == 2'b01) ? {{32{y[31]}}, y} : {32'b0, y};
    p = xe * ye;
    return (m == 2'b00) ? p[31:0] : p[63:32];
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic run_op(input logic [1:0] m, input logic [31:0] x, input logic [31:0] y, input bit hammer);
    int n, pulses;
    logic [31:0] exp;
    exp = model(m, x, y);
    @(negedge clk);
    start = 1'b1; mode = m; a = x; b = y;
    @(posedge clk); #1;
    if (!hammer) start = 1'b0;
    chk("busy_after_start", {31'b0, busy}, 32'd1);
    n = 0;
    while (!done && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (hammer) begin a = $urandom; b = $urandom; mode = 2'($urandom); end
    end
    start = 1'b0;
    chk("latency", n, 33);
    chk("result", result, exp);
    chk("busy_in_done", {31'b0, busy}, 32'd0);
    pulses = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk("single_done", pulses, 0);
    chk("result_held", result, exp);
    last = exp;
  endtask
  initial begin
    #1;
    chk("rst_result", result, 32'd0);
    chk("rst_done_busy", {30'b0, done, busy}, 32'd0);
    @(negedge clk); rst = 1'b0;
    run_op(2'b00, 32'd7, 32'd6, 1'b0);
    chk("mul_7x6", last, 32'd42);
    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    run_op(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    chk("mulhu_ff", result, 32'hFFFFFFFE);
    run_op(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    chk("mulhsu_ff", result, 32'hFFFFFFFF);
    run_op(2'b01, 32'h80000000, 32'h80000000, 1'b0);
    chk("mulh_minmin", result, 32'h40000000);
    run_op(2'b01, 32'h80000000, 32'h00000001, 1'b0);
    run_op(2'b00, 32'h80000000, 32'h00000001, 1'b0);
    run_op(2'b11, 32'd7, 32'd6, 1'b1);
    // flush at edge 10 of a MUL
    @(negedge clk); start = 1'b1; mode = 2'b00; a = 32'd9; b = 32'd9;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    chk("flush_busy", {31'b0, busy}, 32'd0);
    chk("flush_done", {31'b0, done}, 32'd0);
    begin
      int pulses = 0;
      repeat (40) begin @(posedge clk); #1; if (done) pulses++; end
      chk("flush_no_done", pulses, 0);
    end
    chk("flush_result", result, last);
    // flush dominates start in IDLE
    @(negedge clk); start = 1'b1; flush = 1'b1;
    @(posedge clk); #1; start = 1'b0; flush = 1'b0;
    chk("idle_flush_drop", {31'b0, busy}, 32'd0);
    run_op(2'b00, 32'd123, 32'd456, 1'b0);
    for (int i = 0; i < 24; i++) run_op(2'($urandom), $urandom, $urandom, 1'b0);
    // asynchronous reset mid-RUN
    @(negedge clk); start = 1'b1; mode = 2'b01; a = $urandom; b = $urandom;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #3; rst = 1'b1;
    #1;
    chk("arst_result", result, 32'd0);
    chk("arst_busy_done", {30'b0, busy, done}, 32'd0);
    @(negedge clk); rst = 1'b0;
    run_op(2'b00, 32'd3, 32'd5, 1'b0);
    chk("post_rst_3x5", result, 32'd15);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
